// File: rtl/pipe_skid_stage_pkg.sv
// Shared definitions for the pipeline stage registers: FSM state encodings and ctrl bit positions.
package pipe_skid_stage_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_HOLD  = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  localparam int unsigned CTRL_WREG  = 0;
  localparam int unsigned CTRL_M2REG = 1;
  localparam int unsigned CTRL_WMEM  = 2;

  localparam int unsigned OCC_W = 2;

endpackage

// File: rtl/pipe_skid_stage_slot.sv
// One payload register with load enable plus a valid flag that can be cleared.
module pipe_slot #(
  parameter int unsigned W = 8
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         load,
  input  logic         clear,
  input  logic [W-1:0] d,
  output logic [W-1:0] q,
  output logic         valid
);

  // Payload register: captures d on load, otherwise keeps its value.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      q <= '0;
    end else if (load) begin
      q <= d;
    end
  end

  // Valid flag: clear wins over load so a kill always empties the slot.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      valid <= 1'b0;
    end else if (clear) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
    end
  end

endmodule

// File: rtl/pipe_skid_stage.sv
// Elastic pipeline stage: main register plus one skid entry, valid/ready on both sides,
// flush with bubble insertion, occupancy report and a saturating stall counter.
module pipe_skid_stage
  import pipe_skid_stage_pkg::*;
#(
  parameter int unsigned DW = 32,
  parameter int unsigned RW = 5,
  parameter int unsigned CW = 3,
  parameter int unsigned SW = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [CW-1:0]    in_ctrl,
  input  logic [DW-1:0]    in_alu,
  input  logic [DW-1:0]    in_b,
  input  logic [RW-1:0]    in_rn,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CW-1:0]    out_ctrl,
  output logic [DW-1:0]    out_alu,
  output logic [DW-1:0]    out_b,
  output logic [RW-1:0]    out_rn,
  output logic [OCC_W-1:0] occupancy,
  output logic [SW-1:0]    stall_cnt
);

  localparam int unsigned PW      = CW + DW + DW + RW;
  localparam int unsigned ALU_LSB = DW + RW;
  localparam int unsigned B_LSB   = RW;
  localparam logic [SW-1:0] STALL_MAX = '1;

  state_t          state;
  state_t          state_next;
  logic            in_fire;
  logic            out_fire;
  logic            main_load;
  logic            main_clr;
  logic            main_sel_skid;
  logic            skid_load;
  logic            skid_clr;
  logic            main_valid;
  logic            skid_valid;
  logic [PW-1:0]   in_bus;
  logic [PW-1:0]   main_d;
  logic [PW-1:0]   main_q;
  logic [PW-1:0]   skid_q;

  assign in_bus   = {in_ctrl, in_alu, in_b, in_rn};
  assign main_d   = main_sel_skid ? skid_q : in_bus;
  assign in_fire  = in_valid & in_ready;
  assign out_fire = main_valid & out_ready;

  // Main slot feeds the outputs; skid slot absorbs one entry under back-pressure.
  pipe_slot #(.W(PW)) u_main (
    .clock (clock),
    .reset (reset),
    .load  (main_load),
    .clear (main_clr),
    .d     (main_d),
    .q     (main_q),
    .valid (main_valid)
  );

  pipe_slot #(.W(PW)) u_skid (
    .clock (clock),
    .reset (reset),
    .load  (skid_load),
    .clear (skid_clr),
    .d     (in_bus),
    .q     (skid_q),
    .valid (skid_valid)
  );

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= ST_EMPTY;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and slot control; flush overrides every transition.
  always_comb begin
    state_next    = state;
    main_load     = 1'b0;
    main_clr      = 1'b0;
    main_sel_skid = 1'b0;
    skid_load     = 1'b0;
    skid_clr      = 1'b0;
    if (flush) begin
      state_next = ST_EMPTY;
      main_clr   = 1'b1;
      skid_clr   = 1'b1;
    end else begin
      case (state)
        ST_EMPTY: begin
          if (in_fire) begin
            main_load  = 1'b1;
            state_next = ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (in_fire && out_fire) begin
            main_load = 1'b1;
          end else if (in_fire) begin
            skid_load  = 1'b1;
            state_next = ST_FULL;
          end else if (out_fire) begin
            main_clr   = 1'b1;
            state_next = ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (out_fire) begin
            main_load     = 1'b1;
            main_sel_skid = 1'b1;
            skid_clr      = 1'b1;
            state_next    = ST_HOLD;
          end
        end
        default: begin
          state_next = ST_EMPTY;
          main_clr   = 1'b1;
          skid_clr   = 1'b1;
        end
      endcase
    end
  end

  // Saturating count of back-pressured cycles; only reset clears it.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stall_cnt <= '0;
    end else if (main_valid && !out_ready && (stall_cnt != STALL_MAX)) begin
      stall_cnt <= stall_cnt + SW'(1);
    end
  end

  assign in_ready  = ~skid_valid;
  assign out_valid = main_valid;
  assign occupancy = OCC_W'(state);
  assign out_ctrl  = main_q[PW-1 -: CW] & {CW{main_valid}};
  assign out_alu   = main_q[ALU_LSB +: DW];
  assign out_b     = main_q[B_LSB +: DW];
  assign out_rn    = main_q[RW-1:0];

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Scoreboard bench for pipe_skid_stage: a cycle model pushes accepted entries,
// a negedge monitor pops and compares on every output transfer.
module tb_pipe_skid_stage;

  localparam int unsigned DW = 32;
  localparam int unsigned RW = 5;
  localparam int unsigned CW = 3;
  localparam int unsigned SW = 4;
  localparam int unsigned PW = CW + DW + DW + RW;

  logic          clock;
  logic          reset;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [CW-1:0] in_ctrl;
  logic [DW-1:0] in_alu;
  logic [DW-1:0] in_b;
  logic [RW-1:0] in_rn;
  logic          out_valid;
  logic          out_ready;
  logic [CW-1:0] out_ctrl;
  logic [DW-1:0] out_alu;
  logic [DW-1:0] out_b;
  logic [RW-1:0] out_rn;
  logic [1:0]    occupancy;
  logic [SW-1:0] stall_cnt;

  pipe_skid_stage #(.DW(DW), .RW(RW), .CW(CW), .SW(SW)) dut (
    .clock     (clock),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_ctrl   (in_ctrl),
    .in_alu    (in_alu),
    .in_b      (in_b),
    .in_rn     (in_rn),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_ctrl  (out_ctrl),
    .out_alu   (out_alu),
    .out_b     (out_b),
    .out_rn    (out_rn),
    .occupancy (occupancy),
    .stall_cnt (stall_cnt)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_err = 0;

  logic [PW-1:0] sb[$];
  int            m_count = 0;
  int            m_stall = 0;

  logic          p_stall = 1'b0;
  logic          p_flush = 1'b0;
  logic [PW-1:0] p_out = '0;

  task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: tracks held entries and stall count, pushes accepted payloads.
  always @(posedge clock or posedge reset) begin
    int fi;
    int fo;
    if (reset) begin
      m_count = 0;
      m_stall = 0;
      sb.delete();
    end else begin
      if (m_count > 0 && !out_ready && m_stall < 15) m_stall++;
      if (flush) begin
        m_count = 0;
        sb.delete();
      end else begin
        fi = (in_valid && m_count < 2) ? 1 : 0;
        fo = (m_count > 0 && out_ready) ? 1 : 0;
        if (fi == 1) sb.push_back({in_ctrl, in_alu, in_b, in_rn});
        m_count = m_count + fi - fo;
      end
    end
  end

  // Monitor: status against model, payload against scoreboard, stability under stall.
  always @(negedge clock) begin
    logic [PW-1:0] cur;
    logic [PW-1:0] exp;
    cur = {out_ctrl, out_alu, out_b, out_rn};
    chk("occupancy", 80'(occupancy), 80'(m_count));
    chk("in_ready", 80'(in_ready), 80'(m_count < 2));
    chk("out_valid", 80'(out_valid), 80'(m_count > 0));
    chk("stall_cnt", 80'(stall_cnt), 80'(m_stall));
    if (!out_valid) chk("ctrl_gate", 80'(out_ctrl), 80'(0));
    if (p_stall && !p_flush && !reset) chk("stall_stable", 80'(cur), 80'(p_out));
    if (out_valid && out_ready) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_out: got %h expected nothing at %0t", cur, $time);
      end else begin
        exp = sb.pop_front();
        chk("payload", 80'(cur), 80'(exp));
      end
    end
    p_stall = out_valid && !out_ready;
    p_flush = flush;
    p_out   = cur;
  end

  task automatic sync();
    @(posedge clock);
    #1;
  endtask

  task automatic set_in(input logic v, input logic [7:0] tag, input logic rdy);
    in_valid  = v;
    in_alu    = 32'(tag);
    in_ctrl   = 3'(tag);
    in_b      = ~(32'(tag));
    in_rn     = 5'(tag);
    out_ready = rdy;
  endtask

  task automatic put(input logic v, input logic [7:0] tag, input logic rdy);
    set_in(v, tag, rdy);
    sync();
  endtask

  // Directed stimulus followed by a randomized valid/ready/flush run.
  initial begin
    reset = 1'b1;
    flush = 1'b0;
    set_in(1'b0, 8'h00, 1'b0);
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b0;

    // reset mid-stream with in_valid held high
    put(1'b1, 8'hA1, 1'b1);
    put(1'b1, 8'hA2, 1'b1);
    put(1'b1, 8'hA3, 1'b0);
    set_in(1'b1, 8'hA4, 1'b0);
    reset = 1'b1;
    @(negedge clock);
    chk("rst_out_valid", 80'(out_valid), 80'(0));
    chk("rst_in_ready", 80'(in_ready), 80'(1));
    chk("rst_occupancy", 80'(occupancy), 80'(0));
    chk("rst_out_alu", 80'(out_alu), 80'(0));
    chk("rst_out_ctrl", 80'(out_ctrl), 80'(0));
    sync();
    reset = 1'b0;
    set_in(1'b1, 8'h55, 1'b0);
    sync();
    in_valid = 1'b0;
    @(negedge clock);
    chk("first_valid", 80'(out_valid), 80'(1));
    chk("first_alu", 80'(out_alu), 80'(32'h55));
    sync();
    put(1'b0, 8'h00, 1'b1);
    put(1'b0, 8'h00, 1'b1);

    // streaming 1..8 at full rate
    for (int i = 1; i <= 8; i++) put(1'b1, 8'(i), 1'b1);
    put(1'b0, 8'h00, 1'b1);
    put(1'b0, 8'h00, 1'b1);

    // back-pressure into FULL, extra offered entry must not be taken
    put(1'b1, 8'h11, 1'b0);
    put(1'b1, 8'h22, 1'b0);
    put(1'b1, 8'h33, 1'b0);
    @(negedge clock);
    chk("bp_occupancy", 80'(occupancy), 80'(2));
    chk("bp_in_ready", 80'(in_ready), 80'(0));
    chk("bp_out_alu", 80'(out_alu), 80'(32'h11));
    sync();
    repeat (3) put(1'b0, 8'h00, 1'b1);

    // flush in FULL with an offered entry
    put(1'b1, 8'h44, 1'b0);
    put(1'b1, 8'h45, 1'b0);
    set_in(1'b1, 8'h99, 1'b0);
    flush = 1'b1;
    sync();
    flush = 1'b0;
    in_valid = 1'b0;
    @(negedge clock);
    chk("flush_full_valid", 80'(out_valid), 80'(0));
    chk("flush_full_ctrl", 80'(out_ctrl), 80'(0));
    chk("flush_full_occ", 80'(occupancy), 80'(0));
    sync();

    // flush in HOLD with a same-cycle accepted entry
    put(1'b1, 8'h46, 1'b0);
    set_in(1'b1, 8'h47, 1'b0);
    flush = 1'b1;
    sync();
    flush = 1'b0;
    in_valid = 1'b0;
    @(negedge clock);
    chk("flush_hold_occ", 80'(occupancy), 80'(0));
    chk("flush_hold_valid", 80'(out_valid), 80'(0));
    sync();
    repeat (3) put(1'b0, 8'h00, 1'b1);

    // stall counter saturation, unaffected by flush
    put(1'b1, 8'h50, 1'b0);
    repeat (20) put(1'b0, 8'h00, 1'b0);
    @(negedge clock);
    chk("stall_sat", 80'(stall_cnt), 80'(15));
    sync();
    flush = 1'b1;
    sync();
    flush = 1'b0;
    @(negedge clock);
    chk("stall_after_flush", 80'(stall_cnt), 80'(15));
    chk("occ_after_flush", 80'(occupancy), 80'(0));
    sync();

    // random traffic
    for (int c = 0; c < 10000; c++) begin
      in_valid  = 1'($urandom % 2);
      in_ctrl   = 3'($urandom);
      in_alu    = 32'($urandom);
      in_b      = 32'($urandom);
      in_rn     = 5'($urandom);
      out_ready = (($urandom % 4) != 0);
      flush     = (($urandom % 97) == 0);
      sync();
    end
    flush = 1'b0;

    // bounded drain
    set_in(1'b0, 8'h00, 1'b1);
    for (int c = 0; c < 20 && m_count > 0; c++) sync();
    @(negedge clock);
    chk("drain_occupancy", 80'(occupancy), 80'(0));
    chk("drain_scoreboard", 80'(sb.size()), 80'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
